// File: rtl/ram_dist_dp.sv
// Parametrised dual-port distributed RAM with a synchronous clear sequencer and BUSY flag.
// Define RAM_DIST_DP_OREG_EN to register SPO/DPO (1-cycle read latency, read-first).
module ram_dist_dp #(
  parameter int                DATA_W  = 8,
  parameter int                ADDR_W  = 8,
  parameter logic [DATA_W-1:0] CLR_VAL = {DATA_W{1'b0}}
) (
  input  logic              WCLK,
  input  logic              RST,
  input  logic              WE,
  input  logic [ADDR_W-1:0] A,
  input  logic [ADDR_W-1:0] DPRA,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] SPO,
  output logic [DATA_W-1:0] DPO,
  output logic              BUSY
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state = IDLE;
  state_e            state_nxt;
  logic [ADDR_W-1:0] clr_addr = '0;
  logic [ADDR_W-1:0] clr_addr_nxt;
  logic [DATA_W-1:0] mem [DEPTH] = '{default: CLR_VAL};

  function automatic logic [DATA_W-1:0] mask_rd(input logic hide, input logic [DATA_W-1:0] word);
    return hide ? CLR_VAL : word;
  endfunction

  always_ff @(posedge WCLK) begin
    state    <= state_nxt;
    clr_addr <= clr_addr_nxt;
  end

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    if (RST) begin
      state_nxt    = CLEAR;
      clr_addr_nxt = '0;
    end else if (state == CLEAR) begin
      // Last word written on the all-ones address; the pointer wraps back to 0 naturally.
      clr_addr_nxt = clr_addr + 1'b1;
      if (clr_addr == {ADDR_W{1'b1}})
        state_nxt = IDLE;
    end
  end

  assign BUSY = (state == CLEAR);

  always_ff @(posedge WCLK) begin
    if (!RST) begin
      if (state == CLEAR)
        mem[clr_addr] <= CLR_VAL;
      else if (WE)
        mem[A] <= D;
    end
  end

`ifdef RAM_DIST_DP_OREG_EN
  logic [DATA_W-1:0] spo_p1 = CLR_VAL;
  logic [DATA_W-1:0] dpo_p1 = CLR_VAL;

  // Output register stage: captures pre-edge contents (read-first).
  always_ff @(posedge WCLK) begin
    spo_p1 <= mask_rd(BUSY || RST, mem[A]);
    dpo_p1 <= mask_rd(BUSY || RST, mem[DPRA]);
  end

  assign SPO = spo_p1;
  assign DPO = dpo_p1;
`else
  assign SPO = mask_rd(BUSY, mem[A]);
  assign DPO = mask_rd(BUSY, mem[DPRA]);
`endif

endmodule

// File: tb/tb_ram_dist_dp.sv
// Directed bench for ram_dist_dp (256x8): writes, clear sequence, reset mid-clear, optional output register.
module tb_ram_dist_dp;

  logic       WCLK = 1'b0;
  logic       RST  = 1'b0;
  logic       WE   = 1'b0;
  logic [7:0] A    = 8'h00;
  logic [7:0] DPRA = 8'h00;
  logic [7:0] D    = 8'h00;
  logic [7:0] SPO;
  logic [7:0] DPO;
  logic       BUSY;

  int n_chk  = 0;
  int n_fail = 0;

  ram_dist_dp #(.DATA_W(8), .ADDR_W(8), .CLR_VAL(8'h00)) dut (
    .WCLK(WCLK), .RST(RST), .WE(WE), .A(A), .DPRA(DPRA), .D(D),
    .SPO(SPO), .DPO(DPO), .BUSY(BUSY)
  );

  always #5 WCLK = ~WCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge WCLK);
    #1;
  endtask

  // Let a read address take effect on the outputs.
  task automatic settle();
`ifdef RAM_DIST_DP_OREG_EN
    tick();
`else
    #1;
`endif
  endtask

  // Counts edges until BUSY drops, with WE hammering 8'h10 and outputs checked for 0.
  task automatic run_clear(input string tag);
    int n = 0;
    int bad = 0;
    WE = 1'b1; A = 8'h10; D = 8'hFF; DPRA = 8'h10;
    while (BUSY && n < 300) begin
      if (SPO !== 8'h00 || DPO !== 8'h00) bad++;
      tick();
      n++;
    end
    WE = 1'b0;
    chk({tag, "_len"}, n, 256);
    chk({tag, "_out_zero"}, bad, 0);
  endtask

  initial begin
    int bad;

    // Power-up contents and flag
    #1;
    chk("pwr_busy", BUSY, 1'b0);
    A = 8'h00; DPRA = 8'hFF; settle();
    chk("pwr_spo_00", SPO, 8'h00);
    chk("pwr_dpo_ff", DPO, 8'h00);
    A = 8'h5A; DPRA = 8'hA5; settle();
    chk("pwr_spo_5a", SPO, 8'h00);
    chk("pwr_dpo_a5", DPO, 8'h00);

    // Single write, visible on the other port
    WE = 1'b1; A = 8'h3C; D = 8'hA5; tick();
    WE = 1'b0; DPRA = 8'h3C; A = 8'h3D; settle();
    chk("wr_dpo_3c", DPO, 8'hA5);
    chk("wr_spo_3d", SPO, 8'h00);
    A = 8'h3C; settle();
    chk("same_addr_spo", SPO, 8'hA5);
    chk("same_addr_dpo", DPO, 8'hA5);

    // WE=0 leaves contents alone
    D = 8'h77; tick(); settle();
    chk("we0_hold", SPO, 8'hA5);

    // Fill every word with its own address
    WE = 1'b1;
    for (int i = 0; i < 256; i++) begin
      A = 8'(i); D = 8'(i); tick();
    end
    WE = 1'b0;
    A = 8'h7F; DPRA = 8'hFF; settle();
    chk("fill_spo_7f", SPO, 8'h7F);
    chk("fill_dpo_ff", DPO, 8'hFF);
    A = 8'h10; DPRA = 8'h01; settle();
    chk("fill_spo_10", SPO, 8'h10);
    chk("fill_dpo_01", DPO, 8'h01);

    // One-cycle reset pulse starts the clear
    RST = 1'b1; tick();
    chk("rst_busy", BUSY, 1'b1);
    chk("rst_spo", SPO, 8'h00);
    RST = 1'b0;
    run_clear("clr");
    chk("clr_busy_low", BUSY, 1'b0);

    bad = 0;
    for (int i = 0; i < 256; i++) begin
      A = 8'(i); DPRA = 8'(255 - i); settle();
      if (SPO !== 8'h00 || DPO !== 8'h00) bad++;
    end
    chk("clr_all_zero", bad, 0);
    A = 8'h10; settle();
    chk("clr_we_ignored", SPO, 8'h00);

    // Reset mid-clear restarts the sequence
    RST = 1'b1; tick();
    RST = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    chk("mid_busy", BUSY, 1'b1);
    RST = 1'b1; tick(); tick();
    chk("mid_rst_busy", BUSY, 1'b1);
    RST = 1'b0;
    run_clear("reclr");

    // Normal writes resume after the clear
    WE = 1'b1; A = 8'h55; D = 8'hC3; tick();
    WE = 1'b0; DPRA = 8'h55; settle();
    chk("post_wr_dpo", DPO, 8'hC3);
    chk("post_wr_spo", SPO, 8'hC3);

`ifdef RAM_DIST_DP_OREG_EN
    // Read-first on a same-address write through the output register
    WE = 1'b1; A = 8'h05; DPRA = 8'h05; D = 8'h11; tick();
    D = 8'h22; tick();
    WE = 1'b0;
    chk("oreg_old", DPO, 8'h11);
    tick();
    chk("oreg_new", DPO, 8'h22);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
